// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage RV32IC pipeline: load-use shadow tracking, Jalr
// operand hazards, multi-cycle MDU occupancy and data-memory wait freeze.
module hazard_control_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_jalr_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic              ex_mdu_i,
    input  logic              branch_taken_i,
    input  logic              dmem_stall_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              freeze_o,
    output logic              hazard_stall_o,
    output logic              mdu_busy_o,
    output logic              mdu_done_o
);

    // At least one register slot is declared so LOAD_LAT=1 still elaborates.
    localparam int SH_N = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 2);

    typedef enum logic {
        MDU_IDLE,
        MDU_BUSY
    } mdu_state_t;

    mdu_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic              e0_valid;
    logic [REG_AW-1:0] e0_rd;
    logic [SH_N-1:0]   sh_valid_reg;
    logic [REG_AW-1:0] sh_rd_reg [SH_N];

    logic [SH_N:0]     ent_hit_rs1;
    logic [SH_N:0]     ent_hit_rs2;
    logic              rs1_nz, rs2_nz;
    logic              load_hit, jalr_hit, raw;

    // ---------------- load shadow ----------------
    assign e0_valid = ex_memread_i & (ex_rd_i != '0);
    assign e0_rd    = ex_rd_i;

    generate
        if (LOAD_LAT > 1) begin : g_shadow
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    sh_valid_reg <= '0;
                    for (int k = 0; k < SH_N; k++) begin
                        sh_rd_reg[k] <= '0;
                    end
                end else if (!freeze_o) begin
                    sh_valid_reg[0] <= e0_valid;
                    sh_rd_reg[0]    <= e0_rd;
                    for (int k = 1; k < SH_N; k++) begin
                        sh_valid_reg[k] <= sh_valid_reg[k-1];
                        sh_rd_reg[k]    <= sh_rd_reg[k-1];
                    end
                end
            end
        end else begin : g_no_shadow
            assign sh_valid_reg = '0;
            for (genvar gi = 0; gi < SH_N; gi++) begin : g_rd_zero
                assign sh_rd_reg[gi] = '0;
            end
        end
    endgenerate

    assign ent_hit_rs1[0] = e0_valid & (e0_rd == id_rs1_i);
    assign ent_hit_rs2[0] = e0_valid & (e0_rd == id_rs2_i);

    generate
        for (genvar gi = 0; gi < SH_N; gi++) begin : g_hit
            assign ent_hit_rs1[gi+1] = sh_valid_reg[gi] & (sh_rd_reg[gi] == id_rs1_i);
            assign ent_hit_rs2[gi+1] = sh_valid_reg[gi] & (sh_rd_reg[gi] == id_rs2_i);
        end
    endgenerate

    // x0 is filtered on the consumer side so no stored entry can ever match it.
    assign rs1_nz   = (id_rs1_i != '0);
    assign rs2_nz   = (id_rs2_i != '0);
    assign load_hit = (id_use_rs1_i & rs1_nz & (|ent_hit_rs1))
                    | (id_use_rs2_i & rs2_nz & (|ent_hit_rs2));
    assign jalr_hit = id_jalr_i & id_use_rs1_i & rs1_nz
                    & ((ex_regwrite_i & (ex_rd_i == id_rs1_i)) | (|ent_hit_rs1));
    assign raw      = load_hit | jalr_hit;

    // ---------------- MDU occupancy FSM ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= MDU_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mdu_done_o = 1'b0;
        case (state_reg)
            MDU_IDLE: begin
                if (ex_mdu_i) begin
                    state_next = MDU_BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            MDU_BUSY: begin
                // The counter keeps running under a memory wait; only the
                // final hand-off waits for the memory to become ready.
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (!dmem_stall_i) begin
                    state_next = MDU_IDLE;
                    mdu_done_o = 1'b1;
                end
            end
            default: begin
                state_next = MDU_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign mdu_busy_o = (state_reg == MDU_BUSY);

    // ---------------- pipeline control ----------------
    assign freeze_o       = dmem_stall_i
                          | ((state_reg == MDU_IDLE) & ex_mdu_i)
                          | ((state_reg == MDU_BUSY) & (cnt_reg != '0));
    assign hazard_stall_o = raw & ~branch_taken_i & ~freeze_o;
    assign pc_write_o     = ~freeze_o & ~hazard_stall_o;
    assign ifid_write_o   = ~freeze_o & ~hazard_stall_o;
    assign flush_idex_o   = ~freeze_o & (hazard_stall_o | branch_taken_i);
    assign flush_ifid_o   = ~freeze_o & (branch_taken_i | (id_jalr_i & ~hazard_stall_o));

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (LOAD_LAT=3 and LOAD_LAT=1) share
// stimulus; a table, directed sequences and random traffic are checked against a model.
module tb_hazard_control_unit;

    localparam int AW   = 5;
    localparam int MLAT = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [AW-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic          id_use_rs1_i, id_use_rs2_i, id_jalr_i;
    logic          ex_regwrite_i, ex_memread_i, ex_mdu_i;
    logic          branch_taken_i, dmem_stall_i;

    // Output vector order: pc, ifid, flush_ifid, flush_idex, freeze, hazard, busy, done
    logic [7:0] out3, out1;
    logic [7:0] s3, s1;

    hazard_control_unit #(.REG_AW(AW), .LOAD_LAT(3), .MDU_LAT(MLAT), .CNT_W(5)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_jalr_i(id_jalr_i),
        .ex_rd_i(ex_rd_i), .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i),
        .ex_mdu_i(ex_mdu_i), .branch_taken_i(branch_taken_i), .dmem_stall_i(dmem_stall_i),
        .pc_write_o(out3[7]), .ifid_write_o(out3[6]), .flush_ifid_o(out3[5]),
        .flush_idex_o(out3[4]), .freeze_o(out3[3]), .hazard_stall_o(out3[2]),
        .mdu_busy_o(out3[1]), .mdu_done_o(out3[0])
    );

    hazard_control_unit #(.REG_AW(AW), .LOAD_LAT(1), .MDU_LAT(MLAT), .CNT_W(5)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_jalr_i(id_jalr_i),
        .ex_rd_i(ex_rd_i), .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i),
        .ex_mdu_i(ex_mdu_i), .branch_taken_i(branch_taken_i), .dmem_stall_i(dmem_stall_i),
        .pc_write_o(out1[7]), .ifid_write_o(out1[6]), .flush_ifid_o(out1[5]),
        .flush_idex_o(out1[4]), .freeze_o(out1[3]), .hazard_stall_o(out1[2]),
        .mdu_busy_o(out1[1]), .mdu_done_o(out1[0])
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b (pc,ifid,fl_ifid,fl_idex,frz,hz,busy,done)",
                     name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[0] is the load destination (0 = none) that left EX most recently.
    int hist[$];
    bit m_active;
    int m_age;   // which EX cycle (1-based) the running MDU op is in

    function automatic bit model_freeze();
        bit mdu_frz;
        mdu_frz = m_active ? (m_age < MLAT) : ex_mdu_i;
        return dmem_stall_i || mdu_frz;
    endfunction

    function automatic bit model_done();
        return m_active && (m_age >= MLAT) && !dmem_stall_i;
    endfunction

    function automatic int cur_load();
        return (ex_memread_i && ex_rd_i != 0) ? int'(ex_rd_i) : 0;
    endfunction

    function automatic logic [7:0] model_out(input int ll);
        int  loads[$];
        bit  lhit, jhit, frz, hz, br, pcw;
        lhit = 0;
        jhit = 0;
        if (cur_load() != 0) loads.push_back(cur_load());
        for (int i = 0; i < ll - 1; i++) if (hist[i] != 0) loads.push_back(hist[i]);
        foreach (loads[i]) begin
            if (id_use_rs1_i && int'(id_rs1_i) == loads[i]) begin
                lhit = 1;
                if (id_jalr_i) jhit = 1;
            end
            if (id_use_rs2_i && int'(id_rs2_i) == loads[i]) lhit = 1;
        end
        if (id_jalr_i && id_use_rs1_i && ex_regwrite_i && ex_rd_i != 0 && ex_rd_i == id_rs1_i)
            jhit = 1;
        frz = model_freeze();
        br  = branch_taken_i;
        hz  = (lhit || jhit) && !br && !frz;
        pcw = !frz && !hz;
        return {pcw, pcw, !frz && (br || (id_jalr_i && !hz)), !frz && (hz || br),
                frz, hz, m_active, model_done()};
    endfunction

    task automatic model_advance();
        if (!model_freeze()) begin
            hist.push_front(cur_load());
            void'(hist.pop_back());
        end
        if (m_active) begin
            if (model_done()) m_active = 0;
            else m_age++;
        end else if (ex_mdu_i) begin
            m_active = 1;
            m_age    = 2;
        end
    endtask

    task automatic model_reset();
        hist     = '{0, 0, 0};
        m_active = 0;
        m_age    = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic u1, input logic u2, input logic jalr,
                         input logic [AW-1:0] exrd, input logic rw, input logic mr,
                         input logic mdu, input logic br, input logic dm);
        id_rs1_i = rs1; id_rs2_i = rs2; id_use_rs1_i = u1; id_use_rs2_i = u2;
        id_jalr_i = jalr; ex_rd_i = exrd; ex_regwrite_i = rw; ex_memread_i = mr;
        ex_mdu_i = mdu; branch_taken_i = br; dmem_stall_i = dm;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Entered at posedge+1 with inputs applied; samples at the falling edge.
    task automatic step(input string name);
        #4;
        s3 = out3;
        s1 = out1;
        check({name, "_ll3"}, s3, model_out(3));
        check({name, "_ll1"}, s1, model_out(1));
        model_advance();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [AW-1:0] rs1, rs2;
        logic          u1, u2, jalr;
        logic [AW-1:0] exrd;
        logic          rw, mr, br, dm;
        logic [7:0]    exp;
    } vec_t;

    vec_t tbl[12];
    int   hz3, hz1;
    logic [5:0] frz_pat, busy_pat, done_pat;

    initial begin
        tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11000000};
        tbl[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'b00010100};
        tbl[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11000000};
        tbl[3]  = '{5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11000000};
        tbl[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'b11110000};
        tbl[5]  = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00010100};
        tbl[6]  = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11100000};
        tbl[7]  = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 8'b11110000};
        tbl[8]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 8'b00001000};
        tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b00001000};
        tbl[10] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11100000};
        tbl[11] = '{5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'b00010100};

        // Reset state
        idle();
        model_reset();
        #12;
        check("reset_ll3", out3, 8'b11000000);
        check("reset_ll1", out1, 8'b11000000);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Combinational vectors, each separated by enough idle cycles to drain the shadow
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].jalr, tbl[i].exrd,
                  tbl[i].rw, tbl[i].mr, 1'b0, tbl[i].br, tbl[i].dm);
            step("tbl");
            check($sformatf("tbl%0d_ll3", i), s3, tbl[i].exp);
            check($sformatf("tbl%0d_ll1", i), s1, tbl[i].exp);
            idle(); step("tbl_gap");
            idle(); step("tbl_gap");
        end

        // Load shadow: load x7, then ID reads x7 for three cycles
        drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("shadow");
        hz3 = 0; hz1 = 0;
        for (int i = 0; i < 3; i++) begin
            drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step("shadow");
            hz3 += int'(s3[2]);
            hz1 += int'(s1[2]);
        end
        check("shadow_stalls_ll3", 8'(hz3), 8'd2);
        check("shadow_stalls_ll1", 8'(hz1), 8'd0);
        idle(); step("gap");
        idle(); step("gap");

        // Same with a 2-cycle memory wait right after the load
        drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("shadow_frz");
        hz3 = 0; hz1 = 0;
        for (int i = 0; i < 5; i++) begin
            drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, (i < 2));
            step("shadow_frz");
            hz3 += int'(s3[2]);
            hz1 += int'(s1[2]);
        end
        check("shadow_frz_stalls_ll3", 8'(hz3), 8'd2);
        check("shadow_frz_stalls_ll1", 8'(hz1), 8'd0);
        idle(); step("gap");
        idle(); step("gap");

        // MDU op held in EX for its full occupancy
        frz_pat = '0; busy_pat = '0; done_pat = '0;
        for (int i = 0; i < 4; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            step("mdu");
            frz_pat  = {frz_pat[4:0], s3[3]};
            busy_pat = {busy_pat[4:0], s3[1]};
            done_pat = {done_pat[4:0], s3[0]};
        end
        check("mdu_freeze_pat", {4'b0, frz_pat[3:0]}, 8'b00001110);
        check("mdu_busy_pat",   {4'b0, busy_pat[3:0]}, 8'b00000111);
        check("mdu_done_pat",   {4'b0, done_pat[3:0]}, 8'b00000001);
        idle(); step("mdu_after");
        check("mdu_no_retrigger", s3, 8'b11000000);

        // MDU with a 2-cycle memory wait at the final count
        frz_pat = '0; busy_pat = '0; done_pat = '0;
        for (int i = 0; i < 6; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, (i == 3 || i == 4));
            step("mdu_wait");
            frz_pat  = {frz_pat[4:0], s3[3]};
            busy_pat = {busy_pat[4:0], s3[1]};
            done_pat = {done_pat[4:0], s3[0]};
        end
        check("mdu_wait_freeze_pat", {2'b0, frz_pat}, 8'b00111110);
        check("mdu_wait_busy_pat",   {2'b0, busy_pat}, 8'b00011111);
        check("mdu_wait_done_pat",   {2'b0, done_pat}, 8'b00000001);
        idle(); step("gap");

        // Jalr on an ALU result, then release, then with a taken branch
        drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("jalr");
        check("jalr_stall", s3, 8'b00010100);
        drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("jalr");
        check("jalr_release", s3, 8'b11100000);
        drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("jalr");
        check("jalr_branch", s3, 8'b11110000);
        idle(); step("gap");

        // Asynchronous reset while the MDU is busy
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rst_mdu");
        idle();
        #1;
        check("busy_before_rst", out3, 8'b00001010);
        rst_i = 1'b0;
        #1;
        check("rst_mid_mdu_ll3", out3, 8'b11000000);
        check("rst_mid_mdu_ll1", out1, 8'b11000000);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        idle(); step("post_rst");
        check("post_rst_idle", s3, 8'b11000000);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 4) == 0));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised successor to the single-cycle hazard detector for the 5-stage RV32IC core: Jal redirects in IF, Jalr in ID, branches resolve in EX.
- Adds a load-shadow tracker for multi-cycle load-use distance (LOAD_LAT).
- Adds a multi-cycle MDU occupancy FSM and data-memory wait freeze.
- Outputs drive PC/IFID write enables, IFID/IDEX flushes and a global back-end freeze.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, load-use stall distance in stages counted from EX (1 = EX only); range 1..4.
- MDU_LAT, 4, cycles a mul/div occupies EX; range 2..32.
- CNT_W, 5, MDU counter width; must satisfy 2^CNT_W > MDU_LAT.

Ports:
- clk_i in 1: single clock, rising edge.
- rst_i in 1: asynchronous, active-low reset.
- id_rs1_i in REG_AW: ID source 1.
- id_rs2_i in REG_AW: ID source 2.
- id_use_rs1_i in 1: ID instruction reads rs1.
- id_use_rs2_i in 1: ID instruction reads rs2.
- id_jalr_i in 1: ID holds Jalr (target computed in ID).
- ex_rd_i in REG_AW: EX destination.
- ex_regwrite_i in 1: EX writes rd.
- ex_memread_i in 1: EX is a load.
- ex_mdu_i in 1: EX is a mul/div.
- branch_taken_i in 1: EX branch resolved taken.
- dmem_stall_i in 1: data memory not ready.
- pc_write_o out 1: PC update enable.
- ifid_write_o out 1: IF/ID update enable.
- flush_ifid_o out 1: IF/ID becomes bubble.
- flush_idex_o out 1: ID/EX becomes bubble.
- freeze_o out 1: hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- hazard_stall_o out 1: effective data-hazard stall.
- mdu_busy_o out 1: FSM in BUSY.
- mdu_done_o out 1: last MDU cycle, result leaves EX at this edge.

Behaviour:
- Load shadow: entry 0 is combinational: valid = ex_memread_i & ex_rd_i!=0, rd = ex_rd_i.
- Entries 1..LOAD_LAT-1 are registers {valid, rd}. On an edge with freeze_o=0, entry k+1 takes entry k; on an edge with freeze_o=1, all entries hold.
- Load hit: any valid entry whose rd equals id_rs1_i (with id_use_rs1_i) or id_rs2_i (with id_use_rs2_i).
- Jalr hit: id_jalr_i & id_use_rs1_i & ex_regwrite_i & ex_rd_i!=0 & ex_rd_i==id_rs1_i, or any valid load entry matching id_rs1_i.
- Register x0 never causes a hazard.
- raw = load hit | Jalr hit.
- hazard_stall_o = raw & !branch_taken_i & !freeze_o. A taken branch makes ID wrong-path, so the redirect has priority.
- MDU FSM states: IDLE, BUSY. Counter cnt is CNT_W bits.
- IDLE & ex_mdu_i -> BUSY, cnt <= MDU_LAT-2.
- BUSY & cnt!=0 -> cnt decrements, including during dmem_stall_i.
- BUSY & cnt==0 & !dmem_stall_i -> IDLE, mdu_done_o=1.
- BUSY & cnt==0 & dmem_stall_i -> hold BUSY with cnt==0.
- ex_mdu_i is ignored in BUSY; the held instruction must not retrigger.
- mdu_busy_o = (state==BUSY).
- freeze_o = dmem_stall_i | (IDLE & ex_mdu_i) | (BUSY & cnt!=0).
- Net effect: an MDU op occupies EX exactly MDU_LAT cycles when there is no memory wait.
- pc_write_o = ifid_write_o = !freeze_o & !hazard_stall_o.
- flush_idex_o = !freeze_o & (hazard_stall_o | branch_taken_i).
- flush_ifid_o = !freeze_o & (branch_taken_i | (id_jalr_i & !hazard_stall_o)).
- Freeze suppresses all flushes. A branch held under freeze keeps branch_taken_i asserted and flushes on the first unfrozen cycle.
- Reset (asynchronous, active-low): load-shadow valids cleared, FSM IDLE, cnt=0.
- Outputs during reset with all inputs 0: pc_write_o=ifid_write_o=1; every other output 0.
- Reset asserted mid-MDU: immediate IDLE, freeze_o drops with the reset.
- Latency: all stall/flush/freeze outputs are combinational, same cycle as inputs; FSM and shadow update on the rising edge.

Test Plan:
- LOAD_LAT=1, EX load rd=5 with ID rs2=5 used -> hazard_stall_o=1, flush_idex_o=1, pc_write_o=0 for one cycle. Repeat with rd=0 -> no stall.
- LOAD_LAT=3, load rd=7 followed by two independent instructions, third reads x7 -> stalls while the load is in entry 1 or 2, releases after it leaves entry 2. Repeat with freeze_o held 2 cycles mid-way -> shadow holds; stall count unchanged.
- MDU_LAT=4, ex_mdu_i pulse held -> freeze_o high 3 cycles, mdu_done_o on cycle 4, EX advances once; no retrigger.
- MDU in BUSY cnt=0 with dmem_stall_i high 2 cycles -> mdu_done_o delayed 2 cycles; freeze_o continuous.
- ID Jalr rs1=9, EX addi rd=9 -> stall with flush_ifid_o=0. Next cycle with no hazard -> flush_ifid_o=1. Same cycle plus branch_taken_i=1 -> hazard_stall_o=0, both flushes 1, pc_write_o=1.
- rst_i low during MDU BUSY (cnt=2) -> mdu_busy_o=0 and freeze_o=0 immediately; after release, clean IDLE.
